// File: rtl/uart_frame_tx.sv
`default_nettype none
// ============================================================================
// Module  : uart_frame_tx
// Purpose : Buffers scope samples and paces A5 5A LEN <payload> CSUM frames
//           into a byte-level UART transmitter with a fixed inter-byte gap.
// Rev     : 1.0  initial release
// ============================================================================
module uart_frame_tx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 115200,
  parameter int FRAME_LEN = 64,
  parameter int FIFO_AW   = 7
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  input  logic               tx_enable,
  output logic               fifo_full,
  output logic [FIFO_AW:0]   fifo_cnt,
  output logic               overflow,
  output logic               tx_busy,
  output logic               frame_done,
  output logic               uart_en,
  output logic [7:0]         uart_din
);

  localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam int BYTE_GAP = BPS_CNT * 11;
  localparam int DEPTH    = 2 ** FIFO_AW;
  localparam int GAP_W    = $clog2(BYTE_GAP + 1);
  localparam int EN_HOLD  = 4;

  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(BYTE_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_TAIL  = GAP_W'(BYTE_GAP - 2);
  localparam logic [FIFO_AW:0] CNT_START = (FIFO_AW + 1)'(FRAME_LEN);
  localparam logic [FIFO_AW:0] CNT_FULL  = (FIFO_AW + 1)'(DEPTH);
  localparam logic [8:0]       IDX_LAST  = 9'(FRAME_LEN);
  localparam logic [7:0]       LEN_BYTE  = 8'(FRAME_LEN);
  localparam logic [7:0]       SYNC0     = 8'hA5;
  localparam logic [7:0]       SYNC1     = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR0    = 3'd1,
    ST_HDR1    = 3'd2,
    ST_LEN     = 3'd3,
    ST_PAYLOAD = 3'd4,
    ST_CSUM    = 3'd5,
    ST_GAP     = 3'd6
  } state_t;

  state_t             r_state;
  state_t             r_last;
  state_t             w_next;
  logic [GAP_W-1:0]   r_gap;
  logic [1:0]         r_en_hold;
  logic [8:0]         r_idx;
  logic [7:0]         r_csum;
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;

  logic               w_start;
  logic               w_launch;
  logic               w_frame_end;
  logic               w_wr;
  logic               w_rd;
  logic [7:0]         w_byte;
  logic [FIFO_AW:0]   w_cnt_nxt;

  // The gap counter spans the launch cycle plus the GAP cycles, so byte
  // launches land exactly BYTE_GAP clocks apart. The checksum gap ends one
  // clock early so the IDLE decision cycle completes the last byte's gap.
  always_comb begin
    w_start = tx_enable && (fifo_cnt >= CNT_START);
    w_next  = ST_HDR0;
    if (r_state != ST_IDLE) begin
      case (r_last)
        ST_HDR0:    w_next = ST_HDR1;
        ST_HDR1:    w_next = ST_LEN;
        ST_LEN:     w_next = ST_PAYLOAD;
        ST_PAYLOAD: w_next = (r_idx == IDX_LAST) ? ST_CSUM : ST_PAYLOAD;
        default:    w_next = ST_HDR0;
      endcase
    end

    w_launch    = (r_state == ST_IDLE) ? w_start
                : ((r_state == ST_GAP) && (r_last != ST_CSUM) && (r_gap == GAP_LAST));
    w_frame_end = (r_state == ST_GAP) && (r_last == ST_CSUM) && (r_gap == GAP_TAIL);
    w_rd        = w_launch && (w_next == ST_PAYLOAD);
    w_wr        = wr_en && !fifo_full;

    case (w_next)
      ST_HDR0:    w_byte = SYNC0;
      ST_HDR1:    w_byte = SYNC1;
      ST_LEN:     w_byte = LEN_BYTE;
      ST_PAYLOAD: w_byte = r_mem[r_rd_ptr];
      default:    w_byte = r_csum;
    endcase

    w_cnt_nxt = fifo_cnt;
    if (w_wr && !w_rd) begin
      w_cnt_nxt = fifo_cnt + 1'b1;
    end else if (!w_wr && w_rd) begin
      w_cnt_nxt = fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      fifo_cnt  <= '0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      fifo_cnt  <= w_cnt_nxt;
      fifo_full <= (w_cnt_nxt == CNT_FULL);
      overflow  <= wr_en && fifo_full;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_last     <= ST_IDLE;
      r_gap      <= '0;
      r_en_hold  <= '0;
      r_idx      <= '0;
      r_csum     <= '0;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
      uart_en    <= 1'b0;
      uart_din   <= '0;
    end else begin
      frame_done <= 1'b0;

      if (uart_en) begin
        if (r_en_hold == 2'd0) begin
          uart_en <= 1'b0;
        end else begin
          r_en_hold <= r_en_hold - 1'b1;
        end
      end

      if (w_launch) begin
        uart_en   <= 1'b1;
        r_en_hold <= 2'(EN_HOLD - 1);
        uart_din  <= w_byte;
        r_gap     <= '0;
        r_last    <= w_next;
        r_state   <= w_next;
        if (r_state == ST_IDLE) begin
          tx_busy <= 1'b1;
          r_csum  <= '0;
          r_idx   <= '0;
        end
        if (w_next == ST_PAYLOAD) begin
          r_csum <= r_csum + w_byte;
          r_idx  <= r_idx + 1'b1;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
          end
          ST_GAP: begin
            if (w_frame_end) begin
              r_state    <= ST_IDLE;
              tx_busy    <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              r_gap <= r_gap + 1'b1;
            end
          end
          default: begin
            r_state <= ST_GAP;
            r_gap   <= r_gap + 1'b1;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
- Upstream feeder for the byte-level UART transmitter (sys_clk, sys_rst_n, uart_en, uart_din[7:0]).
- Buffers 8-bit scope samples in an internal FIFO. Once FRAME_LEN samples are queued, emits one frame: 0xA5, 0x5A, LEN, FRAME_LEN payload bytes, then an 8-bit checksum.
- The transmitter has no busy output, so this block paces bytes with a fixed inter-byte gap derived from the baud rate.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 115200, baud rate. Must match the transmitter.
- FRAME_LEN, 64, payload bytes per frame. Legal range 1..255.
- FIFO_AW, 7, FIFO address width. Depth is 2**FIFO_AW and must be >= FRAME_LEN.
- Derived localparams:
  - BPS_CNT = CLK_FREQ/UART_BPS.
  - BYTE_GAP = BPS_CNT*11 (10 bit times plus 1 guard bit), in clocks, between successive uart_en rising edges.

Ports:
- sys_clk, in, 1: system clock.
- sys_rst_n, in, 1: asynchronous active-low reset.
- wr_en, in, 1: sample write strobe, one byte per cycle.
- wr_data, in, 8: sample byte.
- tx_enable, in, 1: allows a new frame to start.
- fifo_full, out, 1: FIFO holds 2**FIFO_AW entries.
- fifo_cnt, out, FIFO_AW+1: current FIFO occupancy.
- overflow, out, 1: one-cycle pulse when a write is dropped.
- tx_busy, out, 1: high while a frame is in progress.
- frame_done, out, 1: one-cycle pulse after the checksum byte's gap expires.
- uart_en, out, 1: byte launch to the transmitter, rising-edge significant.
- uart_din, out, 8: byte to the transmitter.

Behaviour:
- One clock, sys_clk. Reset is asynchronous, active-low on sys_rst_n.
- Reset values: all outputs are 0, FIFO is empty, pointers are 0, the checksum is 0, and the state is IDLE.
- Reset mid-frame aborts immediately. The FIFO contents are discarded and no further bytes are launched.

FIFO:
- Write accepted when wr_en=1 and fifo_full=0. wr_en=1 while full drops the byte and pulses overflow on the next cycle.
- Reads are internal, one per payload launch. A simultaneous accepted write and read leaves fifo_cnt unchanged.
- Pointers wrap modulo 2**FIFO_AW.
- fifo_cnt and fifo_full are registered and update the cycle after the event.

State machine: IDLE, HDR0, HDR1, LEN, PAYLOAD, CSUM, GAP.
- IDLE -> HDR0 when tx_enable=1 and fifo_cnt >= FRAME_LEN. In that cycle tx_busy goes to 1 and the checksum clears to 0.
- Launch cycle: entering each byte state loads uart_din, sets uart_en=1, clears the gap counter, and moves to GAP.
- Launched bytes by state:
  - HDR0 launches 0xA5.
  - HDR1 launches 0x5A.
  - LEN launches FRAME_LEN[7:0].
  - PAYLOAD launches the FIFO head byte, advances rd_ptr, adds the byte to the checksum (mod 256), and increments the payload index.
  - CSUM launches the checksum value.
- uart_en stays high for exactly 4 cycles after each launch, then low until the next launch. This gives the transmitter's 2-flop edge detect a clean edge.
- uart_din stays stable from launch until the next launch. After the frame, uart_din holds the checksum value.
- GAP counts 0..BYTE_GAP-1, then moves to the next byte state:
  - HDR1, LEN, and PAYLOAD follow in order.
  - PAYLOAD repeats until the index reaches FRAME_LEN, then CSUM follows.
  - After CSUM, the block pulses frame_done, drops tx_busy, and returns to IDLE.
- Consecutive uart_en rising edges are exactly BYTE_GAP clocks apart. A frame spans (FRAME_LEN+4)*BYTE_GAP clocks from the first launch to frame_done.
- If IDLE's start condition still holds the cycle after return to IDLE, the next frame starts with no extra gap. The last byte's gap has already elapsed.
- tx_enable is sampled only in IDLE. Deasserting it mid-frame does not truncate the frame.
- Checksum: 8-bit sum of the payload bytes only. Headers and LEN are excluded, and carries are discarded.
- Writes continue during a frame. The bytes sent are exactly the FRAME_LEN oldest entries at frame start plus FIFO order. Because the start condition guarantees them, no underflow is possible.

Test Plan:
- Base sequence. Setup: CLK_FREQ=1000000, UART_BPS=100000 (BPS_CNT=10, BYTE_GAP=110), FRAME_LEN=4, FIFO_AW=3. Write 01,02,03,04 with tx_enable=1. Required response:
  - uart_din sequence A5,5A,04,01,02,03,04,0A.
  - Rising edges of uart_en exactly 110 clocks apart, each high for 4 cycles.
  - frame_done pulses 110 clocks after the 0A launch.
  - fifo_cnt returns to 0.
- Checksum wrap: payload FF,FF,FF,02 -> checksum byte FF (0x2FF mod 256).
- Overflow: with tx_enable=0, write 9 bytes -> fifo_full=1 after the 8th write, and overflow pulses once for the 9th write. Then raise tx_enable -> two frames carry bytes 1-4 and 5-8 in order, back to back with a 110-clock spacing across the boundary.
- Concurrent write: write 3 bytes during the first frame's PAYLOAD phase -> no corruption, and fifo_cnt is correct on a simultaneous read/write cycle.
- Reset mid-frame: assert sys_rst_n=0 during the LEN gap -> all outputs read 0 asynchronously, fifo_cnt=0, and no further uart_en edges after release until 4 new bytes are written.
- tx_enable gating: drop tx_enable during PAYLOAD -> the frame completes. Leaving tx_enable=0 with 4 bytes queued -> no new frame until it rises.
